// File: rtl/uart_tx_ctrl.sv
// UART transmit control: host byte FIFO, 11-bit frame assembly and PISO sequencing.
// Runs entirely on baud_clk; rst is asynchronous and active-low.
module uart_tx_ctrl #(
    parameter int DEPTH      = 4,
    parameter bit PARITY_EN  = 1'b1,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                     baud_clk,
    input  logic                     rst,
    input  logic [7:0]               tx_data,
    input  logic                     tx_valid,
    output logic                     tx_ready,
    output logic [10:0]              data_frame,
    output logic                     piso_start,
    input  logic                     piso_active,
    input  logic                     piso_done,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     frame_err
);

    localparam int              AW         = $clog2(DEPTH);
    localparam int              CW         = AW + 1;
    localparam logic [CW-1:0]   FULL_COUNT = CW'(DEPTH);
    localparam logic [10:0]     IDLE_FRAME = 11'h7FF;
    localparam logic [3:0]      LAST_BIT   = 4'd11;

    typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;

    state_t         state_reg, state_next;

    logic [7:0]     fifo_mem [DEPTH];
    logic [AW-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]  count_reg;
    logic           push, pop, fifo_nonempty;

    logic [7:0]     head, head_rev;
    logic           parity_bit;
    logic [10:0]    head_frame;

    logic [10:0]    data_frame_reg, data_frame_next;
    logic           piso_start_reg, piso_start_next;
    logic [3:0]     bit_cnt_reg, bit_cnt_next;
    logic           frame_err_reg, frame_err_next;

    assign fifo_nonempty = (count_reg != '0);
    assign tx_ready      = (count_reg < FULL_COUNT);
    assign push          = tx_valid && tx_ready;
    // The head is consumed exactly on the transition into LOAD.
    assign pop           = fifo_nonempty && ((state_reg == IDLE) || (state_reg == DONE));

    always_ff @(posedge baud_clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= tx_data;
        end
    end

    always_ff @(posedge baud_clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Frame bits 9..2 carry data LSB-first, so the byte is bit-reversed.
    assign head = fifo_mem[rd_ptr_reg];
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_rev
            assign head_rev[7-gi] = head[gi];
        end
    endgenerate

    assign parity_bit = PARITY_EN ? ((^head) ^ PARITY_ODD) : 1'b1;
    assign head_frame = {1'b0, head_rev, parity_bit, 1'b1};

    always_ff @(posedge baud_clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (fifo_nonempty) state_next = LOAD;
            LOAD: state_next = SEND;
            SEND: if (bit_cnt_reg == LAST_BIT) state_next = DONE;
            DONE: state_next = fifo_nonempty ? LOAD : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        data_frame_next = data_frame_reg;
        piso_start_next = piso_start_reg;
        bit_cnt_next    = bit_cnt_reg;
        frame_err_next  = frame_err_reg;
        case (state_reg)
            IDLE: begin
                if (fifo_nonempty) data_frame_next = head_frame;
            end
            LOAD: begin
                piso_start_next = 1'b1;
                bit_cnt_next    = 4'd0;
            end
            SEND: begin
                bit_cnt_next = bit_cnt_reg + 4'd1;
                if (bit_cnt_reg == LAST_BIT) piso_start_next = 1'b0;
            end
            DONE: begin
                if (!piso_done || piso_active) frame_err_next = 1'b1;
                data_frame_next = fifo_nonempty ? head_frame : IDLE_FRAME;
            end
            default: begin
                piso_start_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge baud_clk or negedge rst) begin
        if (!rst) begin
            data_frame_reg <= IDLE_FRAME;
            piso_start_reg <= 1'b0;
            bit_cnt_reg    <= 4'd0;
            frame_err_reg  <= 1'b0;
        end else begin
            data_frame_reg <= data_frame_next;
            piso_start_reg <= piso_start_next;
            bit_cnt_reg    <= bit_cnt_next;
            frame_err_reg  <= frame_err_next;
        end
    end

    assign data_frame = data_frame_reg;
    assign piso_start = piso_start_reg;
    assign frame_err  = frame_err_reg;
    assign fifo_count = count_reg;
    assign busy       = (state_reg != IDLE) || fifo_nonempty;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: behavioural PISO stub, frames predicted from the serial bit order.
// Three instances cover even parity, odd parity and the two-stop-bit format.
module tb_uart_tx_ctrl;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int NB    = DEPTH + 1;

    logic           baud_clk = 1'b0;
    logic           rst      = 1'b1;
    logic [7:0]     tx_data  = 8'h00;
    logic           tx_valid = 1'b0;

    logic           tx_ready, piso_start, busy, frame_err;
    logic [10:0]    data_frame;
    logic [CW-1:0]  fifo_count;
    logic           piso_active, piso_done;

    logic           odd_ready, odd_start, odd_busy, odd_err;
    logic [10:0]    odd_frame;
    logic [CW-1:0]  odd_count;
    logic           np_ready, np_start, np_busy, np_err;
    logic [10:0]    np_frame;
    logic [CW-1:0]  np_count;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    uart_tx_ctrl #(.DEPTH(DEPTH), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_dut (
        .baud_clk(baud_clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .data_frame(data_frame), .piso_start(piso_start),
        .piso_active(piso_active), .piso_done(piso_done), .busy(busy),
        .fifo_count(fifo_count), .frame_err(frame_err)
    );

    uart_tx_ctrl #(.DEPTH(DEPTH), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_odd (
        .baud_clk(baud_clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(odd_ready), .data_frame(odd_frame), .piso_start(odd_start),
        .piso_active(1'b0), .piso_done(1'b1), .busy(odd_busy),
        .fifo_count(odd_count), .frame_err(odd_err)
    );

    uart_tx_ctrl #(.DEPTH(DEPTH), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_np (
        .baud_clk(baud_clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(np_ready), .data_frame(np_frame), .piso_start(np_start),
        .piso_active(1'b0), .piso_done(1'b1), .busy(np_busy),
        .fifo_count(np_count), .frame_err(np_err)
    );

    always #5 baud_clk = ~baud_clk;
    always @(posedge baud_clk) cyc <= cyc + 1;

    // PISO stub: 12 samples of piso_start per frame, flags report completion afterwards.
    int piso_n;
    bit stub_bad = 1'b0;
    bit serial_q[$];
    always @(posedge baud_clk or negedge rst) begin
        if (!rst) begin
            piso_n      <= 0;
            piso_active <= 1'b0;
            piso_done   <= 1'b0;
        end else if (piso_start) begin
            if (piso_n < 11) serial_q.push_back(data_frame[10 - piso_n]);
            if (piso_n == 11) begin
                piso_active <= 1'b0;
                piso_done   <= !stub_bad;
                piso_n      <= 0;
            end else begin
                piso_active <= 1'b1;
                piso_done   <= 1'b0;
                piso_n      <= piso_n + 1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded, required completion");
        $fatal(1);
    end

    // Frame from the on-line bit order: start, data LSB first, parity/stop2, stop.
    function automatic logic [10:0] exp_frame(input logic [7:0] b, input bit pen, input bit podd);
        bit seq[$];
        logic [10:0] f;
        int ones;
        ones = 0;
        seq.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            seq.push_back(b[i]);
            ones += int'(b[i]);
        end
        if (pen) seq.push_back(((ones % 2) == 1) ^ podd);
        else     seq.push_back(1'b1);
        seq.push_back(1'b1);
        for (int k = 0; k < 11; k++) f[10-k] = seq[k];
        return f;
    endfunction

    task automatic push_byte(input logic [7:0] b);
        int g;
        g = 0;
        @(negedge baud_clk);
        tx_data  = b;
        tx_valid = 1'b1;
        while (tx_ready !== 1'b1 && g < 100) begin
            @(negedge baud_clk);
            g++;
        end
        if (g >= 100) begin
            n_checks++;
            $display("FAIL push_timeout: tx_ready=%b required 1", tx_ready);
        end
        @(negedge baud_clk);
        tx_valid = 1'b0;
    endtask

    // Returns at the first negedge after piso_start falls (controller in DONE).
    task automatic wait_frame(output logic [10:0] f, output int edges, output int t0, output bit stable);
        logic [10:0] prev_df;
        int g;
        f = 'x; edges = 0; t0 = -1; stable = 1'b1; g = 0;
        prev_df = data_frame;
        while (piso_start !== 1'b1 && g < 300) begin
            prev_df = data_frame;
            @(negedge baud_clk);
            g++;
        end
        if (g >= 300) begin
            n_checks++;
            $display("FAIL frame_start_timeout: piso_start=%b required 1", piso_start);
            return;
        end
        f  = data_frame;
        t0 = cyc;
        if (prev_df !== f) stable = 1'b0;
        g = 0;
        while (piso_start === 1'b1 && g < 40) begin
            if (data_frame !== f) stable = 1'b0;
            edges++;
            @(negedge baud_clk);
            g++;
        end
    endtask

    task automatic test_reset();
        #2;
        rst = 1'b0;
        #1;
        n_checks++; if (data_frame !== 11'h7FF) $display("FAIL rst_frame: got %h required 7ff", data_frame); else n_pass++;
        n_checks++; if (piso_start !== 1'b0) $display("FAIL rst_start: got %b required 0", piso_start); else n_pass++;
        n_checks++; if (fifo_count !== '0) $display("FAIL rst_count: got %0d required 0", fifo_count); else n_pass++;
        n_checks++; if (frame_err !== 1'b0) $display("FAIL rst_err: got %b required 0", frame_err); else n_pass++;
        n_checks++; if (tx_ready !== 1'b1) $display("FAIL rst_ready: got %b required 1", tx_ready); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b required 0", busy); else n_pass++;
        n_checks++;
        if ({odd_ready, odd_start, odd_busy, odd_err, np_ready, np_start, np_busy, np_err} !== 8'b1000_1000
            || odd_count !== '0 || np_count !== '0 || odd_frame !== 11'h7FF || np_frame !== 11'h7FF)
            $display("FAIL rst_variants: odd r/s/b/e=%b%b%b%b np=%b%b%b%b counts %0d %0d required 1000 1000 0 0",
                     odd_ready, odd_start, odd_busy, odd_err, np_ready, np_start, np_busy, np_err, odd_count, np_count);
        else n_pass++;
        $display("reset: frame=%h start=%b count=%0d ready=%b", data_frame, piso_start, fifo_count, tx_ready);
        repeat (2) @(negedge baud_clk);
        rst = 1'b1;
    endtask

    task automatic test_single();
        logic [10:0] f, exp_f, ser;
        int edges, t0;
        bit stable;
        serial_q.delete();
        push_byte(8'hA5);
        wait_frame(f, edges, t0, stable);
        exp_f = exp_frame(8'hA5, 1'b1, 1'b0);
        $display("single: byte=a5 frame=%h edges=%0d", f, edges);
        n_checks++; if (f !== exp_f) $display("FAIL single_frame: got %h required %h", f, exp_f); else n_pass++;
        n_checks++; if (edges != 12) $display("FAIL single_edges: got %0d required 12", edges); else n_pass++;
        n_checks++; if (!stable) $display("FAIL single_stable: got unstable frame required stable"); else n_pass++;
        @(negedge baud_clk);
        n_checks++; if (serial_q.size() != 11) $display("FAIL serial_len: got %0d required 11", serial_q.size()); else n_pass++;
        ser = 'x;
        for (int k = 0; k < 11; k++) if (k < serial_q.size()) ser[10-k] = serial_q[k];
        n_checks++; if (ser !== exp_f) $display("FAIL serial_bits: got %b required %b", ser, exp_f); else n_pass++;
        n_checks++; if (frame_err !== 1'b0) $display("FAIL single_err: got %b required 0", frame_err); else n_pass++;
        n_checks++; if (data_frame !== 11'h7FF) $display("FAIL single_idle_frame: got %h required 7ff", data_frame); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL single_busy: got %b required 0", busy); else n_pass++;
    endtask

    task automatic test_parity();
        logic [7:0] b;
        logic [10:0] f;
        int edges, t0;
        bit stable;
        for (int i = 0; i < 5; i++) begin
            b = (i == 0) ? 8'h01 : 8'($urandom);
            push_byte(b);
            wait_frame(f, edges, t0, stable);
            $display("parity: byte=%h even=%h odd=%h nopar=%h", b, f, odd_frame, np_frame);
            n_checks++; if (f !== exp_frame(b, 1'b1, 1'b0)) $display("FAIL parity_even: got %h required %h", f, exp_frame(b, 1'b1, 1'b0)); else n_pass++;
            n_checks++; if (odd_frame !== exp_frame(b, 1'b1, 1'b1)) $display("FAIL parity_odd: got %h required %h", odd_frame, exp_frame(b, 1'b1, 1'b1)); else n_pass++;
            n_checks++; if (np_frame !== exp_frame(b, 1'b0, 1'b0)) $display("FAIL parity_none: got %h required %h", np_frame, exp_frame(b, 1'b0, 1'b0)); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [NB];
        for (int i = 0; i < NB; i++) bytes[i] = 8'($urandom);
        fork
            begin : producer
                int idx;
                int g;
                idx = 0; g = 0;
                @(negedge baud_clk);
                while (idx < NB && g < 200) begin
                    tx_data  = bytes[idx];
                    tx_valid = 1'b1;
                    n_checks++;
                    if (tx_ready !== (fifo_count < DEPTH)) $display("FAIL b2b_ready: got %b required %b (count %0d)", tx_ready, (fifo_count < DEPTH), fifo_count); else n_pass++;
                    if (tx_ready === 1'b1) idx++;
                    @(negedge baud_clk);
                    g++;
                end
                tx_valid = 1'b0;
                n_checks++; if (fifo_count !== CW'(DEPTH)) $display("FAIL b2b_full_count: got %0d required %0d", fifo_count, DEPTH); else n_pass++;
                n_checks++; if (tx_ready !== 1'b0) $display("FAIL b2b_full_ready: got %b required 0", tx_ready); else n_pass++;
            end
            begin : consumer
                logic [10:0] f;
                int edges, t0, prev_t0;
                bit stable;
                prev_t0 = 0;
                for (int i = 0; i < NB; i++) begin
                    wait_frame(f, edges, t0, stable);
                    $display("b2b: idx=%0d byte=%h frame=%h start_cycle=%0d edges=%0d", i, bytes[i], f, t0, edges);
                    n_checks++; if (f !== exp_frame(bytes[i], 1'b1, 1'b0)) $display("FAIL b2b_frame%0d: got %h required %h", i, f, exp_frame(bytes[i], 1'b1, 1'b0)); else n_pass++;
                    n_checks++; if (edges != 12 || !stable) $display("FAIL b2b_shape%0d: edges %0d stable %b required 12 1", i, edges, stable); else n_pass++;
                    if (i > 0) begin
                        n_checks++; if (t0 - prev_t0 != 14) $display("FAIL b2b_period%0d: got %0d required 14", i, t0 - prev_t0); else n_pass++;
                    end
                    prev_t0 = t0;
                end
                n_checks++; if (busy !== 1'b1) $display("FAIL b2b_busy_done: got %b required 1", busy); else n_pass++;
                @(negedge baud_clk);
                n_checks++; if (busy !== 1'b0) $display("FAIL b2b_busy_idle: got %b required 0", busy); else n_pass++;
                n_checks++; if (data_frame !== 11'h7FF) $display("FAIL b2b_idle_frame: got %h required 7ff", data_frame); else n_pass++;
                n_checks++; if (frame_err !== 1'b0) $display("FAIL b2b_err: got %b required 0", frame_err); else n_pass++;
            end
        join
    endtask

    task automatic test_push_pop_same();
        logic [7:0] b [4];
        logic [10:0] f;
        int edges, t0;
        bit stable;
        for (int i = 0; i < 4; i++) b[i] = 8'($urandom);
        fork
            begin
                push_byte(b[0]);
                push_byte(b[1]);
                push_byte(b[2]);
            end
            wait_frame(f, edges, t0, stable);
        join
        $display("pushpop: first frame=%h count=%0d", f, fifo_count);
        n_checks++; if (f !== exp_frame(b[0], 1'b1, 1'b0)) $display("FAIL pp_frame0: got %h required %h", f, exp_frame(b[0], 1'b1, 1'b0)); else n_pass++;
        n_checks++; if (fifo_count !== CW'(2)) $display("FAIL pp_count_before: got %0d required 2", fifo_count); else n_pass++;
        tx_data  = b[3];
        tx_valid = 1'b1;
        @(negedge baud_clk);
        tx_valid = 1'b0;
        n_checks++; if (fifo_count !== CW'(2)) $display("FAIL pp_count_after: got %0d required 2", fifo_count); else n_pass++;
        for (int i = 1; i < 4; i++) begin
            wait_frame(f, edges, t0, stable);
            $display("pushpop: idx=%0d byte=%h frame=%h", i, b[i], f);
            n_checks++; if (f !== exp_frame(b[i], 1'b1, 1'b0)) $display("FAIL pp_frame%0d: got %h required %h", i, f, exp_frame(b[i], 1'b1, 1'b0)); else n_pass++;
        end
        @(negedge baud_clk);
    endtask

    task automatic test_frame_err();
        logic [7:0] b;
        logic [10:0] f;
        int edges, t0;
        bit stable;
        stub_bad = 1'b1;
        push_byte(8'($urandom));
        wait_frame(f, edges, t0, stable);
        @(negedge baud_clk);
        stub_bad = 1'b0;
        $display("frame_err: bad completion, err=%b", frame_err);
        n_checks++; if (frame_err !== 1'b1) $display("FAIL err_set: got %b required 1", frame_err); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            b = 8'($urandom);
            push_byte(b);
            wait_frame(f, edges, t0, stable);
            @(negedge baud_clk);
            $display("frame_err: good frame byte=%h frame=%h err=%b", b, f, frame_err);
            n_checks++; if (f !== exp_frame(b, 1'b1, 1'b0)) $display("FAIL err_frame%0d: got %h required %h", i, f, exp_frame(b, 1'b1, 1'b0)); else n_pass++;
            n_checks++; if (frame_err !== 1'b1) $display("FAIL err_sticky%0d: got %b required 1", i, frame_err); else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        logic [10:0] f;
        int edges, t0, g;
        bit stable;
        push_byte(8'($urandom));
        g = 0;
        while (piso_start !== 1'b1 && g < 50) begin
            @(negedge baud_clk);
            g++;
        end
        if (g >= 50) begin
            n_checks++;
            $display("FAIL mid_start_timeout: piso_start=%b required 1", piso_start);
        end
        push_byte(8'($urandom));
        push_byte(8'($urandom));
        @(negedge baud_clk);
        n_checks++; if (fifo_count !== CW'(2)) $display("FAIL mid_count_pre: got %0d required 2", fifo_count); else n_pass++;
        rst = 1'b0;
        #1;
        $display("reset_mid: start=%b frame=%h count=%0d ready=%b err=%b", piso_start, data_frame, fifo_count, tx_ready, frame_err);
        n_checks++; if (piso_start !== 1'b0) $display("FAIL mid_start: got %b required 0", piso_start); else n_pass++;
        n_checks++; if (data_frame !== 11'h7FF) $display("FAIL mid_frame: got %h required 7ff", data_frame); else n_pass++;
        n_checks++; if (fifo_count !== '0) $display("FAIL mid_count: got %0d required 0", fifo_count); else n_pass++;
        n_checks++; if (tx_ready !== 1'b1) $display("FAIL mid_ready: got %b required 1", tx_ready); else n_pass++;
        n_checks++; if (frame_err !== 1'b0) $display("FAIL mid_err: got %b required 0", frame_err); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL mid_busy: got %b required 0", busy); else n_pass++;
        repeat (2) @(negedge baud_clk);
        rst = 1'b1;
        serial_q.delete();
        b = 8'($urandom);
        push_byte(b);
        wait_frame(f, edges, t0, stable);
        @(negedge baud_clk);
        $display("reset_mid: after release byte=%h frame=%h edges=%0d", b, f, edges);
        n_checks++; if (f !== exp_frame(b, 1'b1, 1'b0)) $display("FAIL mid_next_frame: got %h required %h", f, exp_frame(b, 1'b1, 1'b0)); else n_pass++;
        n_checks++; if (edges != 12) $display("FAIL mid_next_edges: got %0d required 12", edges); else n_pass++;
        n_checks++; if (frame_err !== 1'b0 || busy !== 1'b0) $display("FAIL mid_next_state: err %b busy %b required 0 0", frame_err, busy); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_parity();
        test_back_to_back();
        test_push_pop_same();
        test_frame_err();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
